// File: rtl/hps_pkg.sv
// Shared constants and state type for the HPS peak detector.
package hps_pkg;

    localparam int HPS_DATA_WIDTH = 24;
    localparam int HPS_NUM_BINS   = 512;
    localparam int HPS_MIN_BIN    = 4;

    // SCAN: consuming a frame. HOLD: presenting a result until accepted.
    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } hps_peak_state_t;

endpackage

// File: rtl/hps_peak_detect_if.sv
// Bin stream in, peak result out.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid && ready. Once the source raises valid, it keeps valid and
// its payload stable until that transfer. The sink may change ready at any
// time. Raising ready before valid does nothing.
interface hps_peak_detect_if #(
    parameter int DATA_WIDTH = 24,
    parameter int BIN_WIDTH  = 9
);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;

    logic                  m_valid;
    logic                  m_ready;
    logic [BIN_WIDTH-1:0]  m_bin;
    logic [DATA_WIDTH-1:0] m_mag;
    logic                  m_voiced;
    logic                  m_overflow;

    // Upstream bin source plus downstream result consumer.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_bin, m_mag, m_voiced, m_overflow
    );

    // The peak detector itself.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_bin, m_mag, m_voiced, m_overflow
    );

endinterface

// File: rtl/hps_peak_detect.sv
// Frame peak search over HPS product magnitudes with a voicing decision.
// The result is held until the pitch-shift control accepts it.
module hps_peak_detect
    import hps_pkg::*;
#(
    parameter int DATA_WIDTH = HPS_DATA_WIDTH,
    parameter int NUM_BINS   = HPS_NUM_BINS,
    parameter int MIN_BIN    = HPS_MIN_BIN,
    localparam int BIN_WIDTH = $clog2(NUM_BINS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] threshold,
    hps_peak_detect_if.slave      bus,
    output hps_peak_state_t       fsm_state
);

    localparam logic [BIN_WIDTH-1:0] LAST_IDX = BIN_WIDTH'(NUM_BINS - 1);
    localparam logic [BIN_WIDTH-1:0] MIN_IDX  = BIN_WIDTH'(MIN_BIN);
    // A MIN_BIN at or beyond the frame size leaves no searchable bin.
    localparam bit MIN_OK = (MIN_BIN < NUM_BINS);

    hps_peak_state_t state, state_next;
    logic            s_ready_int, m_valid_int;

    // Per-frame search state.
    logic [BIN_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] best_mag;
    logic [BIN_WIDTH-1:0]  best_bin;
    logic                  seen_cand;
    logic                  ovf;
    logic                  started;
    logic [DATA_WIDTH-1:0] thr_q;

    // Held result.
    logic [BIN_WIDTH-1:0]  res_bin;
    logic [DATA_WIDTH-1:0] res_mag;
    logic                  res_voiced;
    logic                  res_ovf;

    logic                  accept;
    logic                  finish;
    logic                  handshake;
    logic                  at_end;
    logic                  candidate;
    logic                  take;
    logic [DATA_WIDTH-1:0] mag_next;
    logic [BIN_WIDTH-1:0]  bin_next;
    logic                  cand_next;
    logic                  ovf_next;
    logic [DATA_WIDTH-1:0] thr_eff;

    assign accept    = bus.s_valid && s_ready_int;
    assign finish    = accept && bus.s_last;
    assign handshake = m_valid_int && bus.m_ready;
    assign at_end    = (cnt == LAST_IDX);

    // Once a frame has run past the last bin, nothing more is compared.
    assign candidate = MIN_OK && (cnt >= MIN_IDX) && !ovf;
    // Strict compare: on a tie the earlier (lower) bin keeps the peak.
    assign take      = accept && candidate && (bus.s_data > best_mag);
    assign mag_next  = take ? bus.s_data : best_mag;
    assign bin_next  = take ? cnt : best_bin;
    assign cand_next = seen_cand || (accept && candidate);
    assign ovf_next  = ovf || (accept && at_end && !bus.s_last);
    // The threshold belongs to the frame's first beat; a one-beat frame
    // must see it the same cycle.
    assign thr_eff   = started ? thr_q : threshold;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_next  = state;
        s_ready_int = 1'b0;
        m_valid_int = 1'b0;
        case (state)
            SCAN: begin
                // Ready is masked while reset is held so upstream sees no
                // acceptance during reset.
                s_ready_int = reset_n;
                if (bus.s_valid && bus.s_last && reset_n) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                m_valid_int = 1'b1;
                if (bus.m_ready) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Bin counter, running best and overflow tracking; cleared after each
    // accepted result so the next frame starts clean.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            best_mag  <= '0;
            best_bin  <= '0;
            seen_cand <= 1'b0;
            ovf       <= 1'b0;
            started   <= 1'b0;
            thr_q     <= '0;
        end else if (handshake) begin
            cnt       <= '0;
            best_mag  <= '0;
            best_bin  <= '0;
            seen_cand <= 1'b0;
            ovf       <= 1'b0;
            started   <= 1'b0;
        end else if (accept) begin
            if (!at_end) begin
                cnt <= cnt + 1'b1;
            end
            best_mag  <= mag_next;
            best_bin  <= bin_next;
            seen_cand <= cand_next;
            ovf       <= ovf_next;
            started   <= 1'b1;
            if (!started) begin
                thr_q <= threshold;
            end
        end
    end

    // Result capture on the last beat, including that beat's comparison.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_bin    <= '0;
            res_mag    <= '0;
            res_voiced <= 1'b0;
            res_ovf    <= 1'b0;
        end else if (finish) begin
            res_bin    <= bin_next;
            res_mag    <= mag_next;
            res_voiced <= cand_next && (mag_next >= thr_eff);
            res_ovf    <= ovf_next;
        end
    end

    assign bus.s_ready    = s_ready_int;
    assign bus.m_valid    = m_valid_int;
    assign bus.m_bin      = res_bin;
    assign bus.m_mag      = res_mag;
    assign bus.m_voiced   = res_voiced;
    assign bus.m_overflow = res_ovf;
    assign fsm_state      = state;

endmodule
